raizing_gfx_arb: RTL

Four-way arbiter that shares one graphics-ROM read port between the sprite engine (OBJ) and the three scroll layers (SCR0–SCR2). It sits between those layers' tile fetchers and the single SDRAM/ROM slot, replacing four dedicated ROM channels. Grants are round-robin. Each requester gets a one-entry result cache, so its OK stays asserted while it holds CS on the same address. The cache can be flushed on tile-bank changes.

---
 rtl/raizing_gfx_pkg.sv | 30 +++
 rtl/raizing_gfx_rr.sv | 37 +++
 rtl/raizing_gfx_arb.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/raizing_gfx_pkg.sv
//==============================================================================
// Module   : raizing_gfx_pkg
// Purpose  : Shared constants and types for the graphics-ROM arbiter.
//            Holds the default ROM address/data widths, the requester
//            index assignments and the arbiter FSM state encoding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package raizing_gfx_pkg;

    localparam int GFX_AW  = 22;   // ROM word-address width
    localparam int GFX_DW  = 32;   // ROM data width
    localparam int N_PORTS = 4;

    // Requester indices
    localparam logic [1:0] PORT_OBJ  = 2'd0;
    localparam logic [1:0] PORT_SCR0 = 2'd1;
    localparam logic [1:0] PORT_SCR1 = 2'd2;
    localparam logic [1:0] PORT_SCR2 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/raizing_gfx_rr.sv
//==============================================================================
// Module   : raizing_gfx_rr
// Purpose  : Combinational 4-way round-robin picker. Searches
//            last+1, last+2, last+3, last (mod 4) and returns the first
//            pending index found.
// Ports    : i_pend [3:0]  pending request bits
//            i_last [1:0]  most recently granted index
//            o_g    [1:0]  selected index (valid when o_any)
//            o_any         at least one request pending
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module raizing_gfx_rr
    import raizing_gfx_pkg::*;
(
    input  logic [3:0] i_pend,
    input  logic [1:0] i_last,
    output logic [1:0] o_g,
    output logic       o_any
);

    // Walk from the lowest priority offset (last itself) up to last+1 so the
    // final assignment is the highest-priority pending index.
    always_comb begin
        o_g   = i_last;
        o_any = |i_pend;
        for (int k = N_PORTS; k >= 1; k--) begin
            if (i_pend[2'(i_last + 2'(k))]) begin
                o_g = 2'(i_last + 2'(k));
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/raizing_gfx_arb.sv
//==============================================================================
// Module   : raizing_gfx_arb
// Purpose  : Shares one graphics-ROM read port between OBJ and SCR0..SCR2.
//            Round-robin grants, one-entry result cache per requester so
//            OK stays asserted while a requester holds CS on the same
//            address. FLUSH invalidates every cache entry.
// Ports    : CLK, RESET          clock, synchronous active-high reset
//            REQ_CS/REQ_ADDR     per-requester strobe and word address
//            REQ_OK/REQ_DOUT     per-requester hit flag and cached data
//            FLUSH               one-cycle cache invalidate
//            ROM_CS/ROM_ADDR     downstream request
//            ROM_OK/ROM_DOUT     downstream response
//            BUSY                arbiter not idle
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module raizing_gfx_arb
    import raizing_gfx_pkg::*;
#(
    parameter int AW = GFX_AW,
    parameter int DW = GFX_DW
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [3:0]          REQ_CS,
    input  logic [3:0][AW-1:0]  REQ_ADDR,
    output logic [3:0]          REQ_OK,
    output logic [3:0][DW-1:0]  REQ_DOUT,
    input  logic                FLUSH,
    output logic                ROM_CS,
    output logic [AW-1:0]       ROM_ADDR,
    input  logic                ROM_OK,
    input  logic [DW-1:0]       ROM_DOUT,
    output logic                BUSY
);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic               r_first;       // set during the first WAIT cycle
    logic [1:0]         r_gnt;
    logic [1:0]         r_last;
    logic               r_rom_cs;
    logic [AW-1:0]      r_rom_addr;
    logic [3:0]         r_vld;
    logic [3:0][AW-1:0] r_tag;
    logic [3:0][DW-1:0] r_dat;

    logic [3:0]         w_hit;
    logic [3:0]         w_pend;
    logic [1:0]         w_g;
    logic               w_any;
    logic               w_launch;
    logic               w_fill;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_port
            assign w_hit[i]  = r_vld[i] && (r_tag[i] == REQ_ADDR[i]);
            assign w_pend[i] = REQ_CS[i] && !w_hit[i];
            assign REQ_OK[i] = REQ_CS[i] && w_hit[i];
        end
    endgenerate

    assign REQ_DOUT = r_dat;
    assign ROM_CS   = r_rom_cs;
    assign ROM_ADDR = r_rom_addr;
    assign BUSY     = (r_state != ST_IDLE);

    raizing_gfx_rr u_rr (
        .i_pend (w_pend),
        .i_last (r_last),
        .o_g    (w_g),
        .o_any  (w_any)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ROM_OK may still be high from the previous address during the first
    // WAIT cycle, so completion is only accepted once r_first has cleared.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!r_first && ROM_OK) begin
                    w_fill      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_first    <= 1'b0;
            r_gnt      <= 2'd0;
            r_last     <= 2'd3;
            r_rom_cs   <= 1'b0;
            r_rom_addr <= '0;
            r_vld      <= '0;
            r_tag      <= '0;
            r_dat      <= '0;
        end else begin
            if (w_launch) begin
                r_gnt      <= w_g;
                r_last     <= w_g;
                r_rom_addr <= REQ_ADDR[w_g];
                r_rom_cs   <= 1'b1;
                r_first    <= 1'b1;
            end else if (r_state == ST_WAIT) begin
                r_first    <= 1'b0;
            end

            // The fill always records the latched address, so a requester
            // that moved on during WAIT simply misses and re-arbitrates.
            if (w_fill) begin
                r_tag[r_gnt] <= r_rom_addr;
                r_dat[r_gnt] <= ROM_DOUT;
                r_rom_cs     <= 1'b0;
            end

            // FLUSH takes priority over a coincident fill.
            if (FLUSH) begin
                r_vld <= '0;
            end else if (w_fill) begin
                r_vld[r_gnt] <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
